// File: rtl/bus_ctrl_pkg.sv
// Shared definitions for the bus transfer controller, register bank and bus mux:
// FSM state encoding, default bus geometry and a register-index range helper.
package bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_NUM_REG = 8;
    localparam int DEF_SEL_W   = 3;

    function automatic logic idx_in_range(input int idx, input int num_reg);
        return (idx < num_reg) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/bus_transfer_arbiter_if.sv
// Requester-side handshake and register-bus control signals of the transfer arbiter.
// The master modport is the requester/bank side, the slave modport is the arbiter.
interface bus_transfer_arbiter_if #(
    parameter int NUM_REQ = bus_ctrl_pkg::DEF_NUM_REQ,
    parameter int NUM_REG = bus_ctrl_pkg::DEF_NUM_REG,
    parameter int SEL_W   = bus_ctrl_pkg::DEF_SEL_W
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*SEL_W-1:0] src_sel;
    logic [NUM_REQ*SEL_W-1:0] dst_sel;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       ack;
    logic                     err;
    logic [SEL_W-1:0]         bus_sel;
    logic [NUM_REG-1:0]       load_en;
    logic                     busy;

    modport master (
        output req, src_sel, dst_sel,
        input  grant, ack, err, bus_sel, load_en, busy
    );

    modport slave (
        input  req, src_sel, dst_sel,
        output grant, ack, err, bus_sel, load_en, busy
    );

endinterface

// File: rtl/bus_transfer_arbiter_rr_arbiter.sv
// Round-robin picker: searches from the slot after the last winner and moves its
// pointer only when the caller says the winner was actually granted.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               any_req
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] idx_s;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;
    logic             hit_s;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        found_s = 1'b0;
        idx_s   = '0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_s  = IDX_W'((int'(ptr_r) + off) % NUM_REQ);
            hit_s   = ~found_s & req[cand_s];
            idx_s   = hit_s ? cand_s : idx_s;
            found_s = found_s | hit_s;
        end
    end

    // One-hot decode of the chosen index.
    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            winner[i] = found_s & (idx_s == IDX_W'(i));
        end
    end

    assign winner_idx = idx_s;
    assign any_req    = found_s;

    // Pointer steps past the granted core; it stays put when nobody is granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= '0;
        end else if (advance) begin
            ptr_r <= (idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : idx_s + IDX_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/bus_transfer_arbiter.sv
// Shares the register data bus between requesting cores: one register-to-register
// move per grant, sequenced IDLE -> SETUP -> LOAD -> DONE with all outputs registered.
module bus_transfer_arbiter
    import bus_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int NUM_REG = DEF_NUM_REG,
    parameter int SEL_W   = DEF_SEL_W
) (
    input  logic                   clk,
    input  logic                   reset,
    bus_transfer_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state_r;
    logic [NUM_REQ-1:0] grant_r;
    logic [NUM_REQ-1:0] ack_r;
    logic               err_r;
    logic [SEL_W-1:0]   bus_sel_r;
    logic [SEL_W-1:0]   src_r;
    logic [SEL_W-1:0]   dst_r;
    logic [NUM_REG-1:0] load_en_r;
    logic               busy_r;

    logic [NUM_REQ-1:0] winner_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               any_s;
    logic               advance_s;
    logic [SEL_W-1:0]   win_src_s;
    logic [SEL_W-1:0]   win_dst_s;
    logic               idx_ok_s;

    assign advance_s = (state_r == ST_IDLE) & any_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk        (clk),
        .reset      (reset),
        .req        (bus.req),
        .advance    (advance_s),
        .winner     (winner_s),
        .winner_idx (win_idx_s),
        .any_req    (any_s)
    );

    // Select the winning core's source/destination fields from the packed vectors.
    always_comb begin
        win_src_s = '0;
        win_dst_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_src_s = (win_idx_s == IDX_W'(i)) ? bus.src_sel[i*SEL_W +: SEL_W] : win_src_s;
            win_dst_s = (win_idx_s == IDX_W'(i)) ? bus.dst_sel[i*SEL_W +: SEL_W] : win_dst_s;
        end
    end

    assign idx_ok_s = idx_in_range(int'(src_r), NUM_REG) & idx_in_range(int'(dst_r), NUM_REG);

    // Transfer sequencer; src/dst are frozen at grant so requesters may change them freely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            grant_r   <= '0;
            ack_r     <= '0;
            err_r     <= 1'b0;
            bus_sel_r <= '0;
            src_r     <= '0;
            dst_r     <= '0;
            load_en_r <= '0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        state_r   <= ST_SETUP;
                        grant_r   <= winner_s;
                        src_r     <= win_src_s;
                        dst_r     <= win_dst_s;
                        bus_sel_r <= win_src_s;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    state_r <= ST_LOAD;
                    // A self-move or an out-of-range index never strobes a register.
                    if (idx_ok_s && (src_r != dst_r)) begin
                        load_en_r <= {{(NUM_REG-1){1'b0}}, 1'b1} << dst_r;
                    end else begin
                        load_en_r <= '0;
                    end
                end
                ST_LOAD: begin
                    state_r   <= ST_DONE;
                    load_en_r <= '0;
                    ack_r     <= grant_r;
                    err_r     <= ~idx_ok_s;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    ack_r   <= '0;
                    err_r   <= 1'b0;
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    grant_r   <= '0;
                    ack_r     <= '0;
                    err_r     <= 1'b0;
                    load_en_r <= '0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant   = grant_r;
    assign bus.ack     = ack_r;
    assign bus.err     = err_r;
    assign bus.bus_sel = bus_sel_r;
    assign bus.load_en = load_en_r;
    assign bus.busy    = busy_r;

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Bench for bus_transfer_arbiter: an 8-register instance with a register-bank model and
// ack scoreboard, plus a 6-register instance for out-of-range index handling.
module tb_bus_transfer_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    typedef struct {
        int          core;
        int          src;
        int          dst;
        bit          load;
        logic [15:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] regs[8];
    bit          bank_init;

    bus_transfer_arbiter_if #(.NUM_REQ(4), .NUM_REG(8), .SEL_W(3)) bus0 ();
    bus_transfer_arbiter_if #(.NUM_REQ(4), .NUM_REG(6), .SEL_W(3)) bus1 ();

    bus_transfer_arbiter #(.NUM_REQ(4), .NUM_REG(8), .SEL_W(3)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    bus_transfer_arbiter #(.NUM_REQ(4), .NUM_REG(6), .SEL_W(3)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: the strobed register takes the bus value on the falling edge.
    always @(negedge clk) begin
        if (!bank_init) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'hA000 + 16'(i);
            bank_init <= 1'b1;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (bus0.load_en[i]) regs[i] <= regs[bus0.bus_sel];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_sel0(input int core, input int src, input int dst);
        bus0.src_sel[core*3 +: 3] = 3'(src);
        bus0.dst_sel[core*3 +: 3] = 3'(dst);
    endtask

    task automatic push0(input int core, input int src, input int dst, input bit load);
        exp_t e;
        e.core = core; e.src = src; e.dst = dst; e.load = load;
        e.val  = load ? regs[src] : regs[dst];
        sb_q.push_back(e);
    endtask

    task automatic wait_grant(input int which, output int cyc);
        logic [3:0] g;
        cyc = 0;
        g   = 4'd0;
        while (g == 4'd0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            g = (which == 0) ? bus0.grant : bus1.grant;
        end
        if (g == 4'd0) check_val("grant_timeout", 32'(cyc), 32'd0);
    endtask

    // Called with the DUT in SETUP; walks SETUP, LOAD, DONE and the following IDLE.
    task automatic follow0(input int core, input int src, input int dst, input bit load);
        logic [3:0] g;
        logic [7:0] le;
        g  = 4'(1) << core;
        le = load ? (8'(1) << dst) : 8'd0;
        check_val("setup_grant", 32'(bus0.grant), 32'(g));
        check_val("setup_sel", 32'(bus0.bus_sel), 32'(src));
        check_val("setup_load", 32'(bus0.load_en), 32'd0);
        check_val("setup_busy", 32'(bus0.busy), 32'd1);
        @(posedge clk); #1;
        check_val("load_en", 32'(bus0.load_en), 32'(le));
        check_val("load_sel", 32'(bus0.bus_sel), 32'(src));
        check_val("load_grant", 32'(bus0.grant), 32'(g));
        check_val("load_ack", 32'(bus0.ack), 32'd0);
        @(posedge clk); #1;
        check_val("done_ack", 32'(bus0.ack), 32'(g));
        check_val("done_load", 32'(bus0.load_en), 32'd0);
        check_val("done_sel", 32'(bus0.bus_sel), 32'(src));
        check_val("done_grant", 32'(bus0.grant), 32'(g));
        @(posedge clk); #1;
        check_val("idle_busy", 32'(bus0.busy), 32'd0);
        check_val("idle_grant", 32'(bus0.grant), 32'd0);
        check_val("idle_ack", 32'(bus0.ack), 32'd0);
        check_val("idle_sel", 32'(bus0.bus_sel), 32'(src));
    endtask

    task automatic xfer1(input int core, input int src, input int dst, input logic [5:0] le, input bit e);
        int         cyc;
        logic [3:0] g;
        g = 4'(1) << core;
        bus1.src_sel[core*3 +: 3] = 3'(src);
        bus1.dst_sel[core*3 +: 3] = 3'(dst);
        bus1.req = g;
        wait_grant(1, cyc);
        check_val("r6_grant", 32'(bus1.grant), 32'(g));
        @(posedge clk); #1;
        check_val("r6_load", 32'(bus1.load_en), 32'(le));
        check_val("r6_sel", 32'(bus1.bus_sel), 32'(src));
        @(posedge clk); #1;
        check_val("r6_ack", 32'(bus1.ack), 32'(g));
        check_val("r6_err", 32'(bus1.err), 32'(e));
        check_val("r6_load_done", 32'(bus1.load_en), 32'd0);
        @(posedge clk); #1;
        bus1.req = 4'd0;
        check_val("r6_idle_err", 32'(bus1.err), 32'd0);
        check_val("r6_idle_busy", 32'(bus1.busy), 32'd0);
    endtask

    // Scoreboard: every ack pops the oldest expected transfer and checks its effects.
    initial begin
        int         loads;
        logic [7:0] last;
        loads = 0;
        last  = 8'd0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                loads = 0;
                last  = 8'd0;
            end else begin
                if (bus0.load_en != 8'd0) begin
                    loads++;
                    last = bus0.load_en;
                    check_val("load_onehot", 32'($countones(bus0.load_en)), 32'd1);
                end
                if (bus0.ack != 4'd0) begin
                    if (sb_q.size() == 0) begin
                        check_val("ack_unexpected", 32'(bus0.ack), 32'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check_val("sb_ack", 32'(bus0.ack), 32'(4'(1) << e.core));
                        check_val("sb_err", 32'(bus0.err), 32'd0);
                        check_val("sb_loads", 32'(loads), e.load ? 32'd1 : 32'd0);
                        check_val("sb_load_bit", 32'(last), e.load ? 32'(8'(1) << e.dst) : 32'd0);
                        check_val("sb_reg", 32'(regs[e.dst]), 32'(e.val));
                    end
                    loads = 0;
                    last  = 8'd0;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          c;
        int          prev;
        logic [15:0] keep;
        checks = 0;
        errors = 0;
        prev   = 0;
        reset  = 1'b0;
        bus0.req = 4'd0; bus0.src_sel = 12'd0; bus0.dst_sel = 12'd0;
        bus1.req = 4'd0; bus1.src_sel = 12'd0; bus1.dst_sel = 12'd0;
        for (int i = 0; i < 4; i++) set_sel0(i, i, i + 4);
        bus0.req = 4'b1111;

        // Reset held with every core requesting.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_grant", 32'(bus0.grant), 32'd0);
        check_val("rst_ack", 32'(bus0.ack), 32'd0);
        check_val("rst_err", 32'(bus0.err), 32'd0);
        check_val("rst_bus_sel", 32'(bus0.bus_sel), 32'd0);
        check_val("rst_load_en", 32'(bus0.load_en), 32'd0);
        check_val("rst_busy", 32'(bus0.busy), 32'd0);
        reset = 1'b1;

        // Fairness with all cores requesting: 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            c = k % 4;
            push0(c, c, c + 4, 1'b1);
            wait_grant(0, cyc);
            if (k > 0) bus0.req[prev] = 1'b1;
            follow0(c, c, c + 4, 1'b1);
            bus0.req[c] = 1'b0;
            prev = c;
        end
        bus0.req = 4'd0;
        @(posedge clk); #1;

        // Single transfer, core 2: reg5 -> reg1, grant one edge after the request.
        set_sel0(2, 5, 1);
        push0(2, 5, 1, 1'b1);
        bus0.req = 4'b0100;
        wait_grant(0, cyc);
        check_val("lat_grant", 32'(cyc), 32'd1);
        follow0(2, 5, 1, 1'b1);
        bus0.req = 4'd0;

        // Self-move is a no-op that still acks.
        set_sel0(3, 3, 3);
        push0(3, 3, 3, 1'b0);
        bus0.req = 4'b1000;
        wait_grant(0, cyc);
        follow0(3, 3, 3, 1'b0);
        bus0.req = 4'd0;

        // Core 1 drops its request during SETUP; the transfer still completes.
        set_sel0(1, 6, 0);
        push0(1, 6, 0, 1'b1);
        bus0.req = 4'b0010;
        wait_grant(0, cyc);
        bus0.req = 4'd0;
        follow0(1, 6, 0, 1'b1);

        // Source changes after grant; the latched source stays on the bus.
        set_sel0(0, 2, 6);
        push0(0, 2, 6, 1'b1);
        bus0.req = 4'b0001;
        wait_grant(0, cyc);
        set_sel0(0, 4, 5);
        follow0(0, 2, 6, 1'b1);
        bus0.req = 4'd0;

        // Reset during LOAD aborts the move; the pointer restarts at core 0.
        set_sel0(2, 0, 3);
        bus0.req = 4'b0100;
        wait_grant(0, cyc);
        check_val("abort_grant", 32'(bus0.grant), 32'b0100);
        keep = regs[3];
        @(posedge clk); #1;
        check_val("abort_load_on", 32'(bus0.load_en), 32'b1000);
        #2 reset = 1'b0;
        #1;
        check_val("abort_load_off", 32'(bus0.load_en), 32'd0);
        check_val("abort_grant_off", 32'(bus0.grant), 32'd0);
        check_val("abort_busy", 32'(bus0.busy), 32'd0);
        @(posedge clk); #1;
        check_val("abort_no_ack", 32'(bus0.ack), 32'd0);
        check_val("abort_reg", 32'(regs[3]), 32'(keep));
        for (int i = 0; i < 4; i++) set_sel0(i, 7, 2);
        push0(0, 7, 2, 1'b1);
        bus0.req = 4'b1111;
        reset = 1'b1;
        wait_grant(0, cyc);
        follow0(0, 7, 2, 1'b1);
        bus0.req = 4'd0;

        // Six-register instance: out-of-range indices flag err and never strobe.
        xfer1(0, 2, 7, 6'd0, 1'b1);
        xfer1(1, 6, 1, 6'd0, 1'b1);
        xfer1(2, 1, 2, 6'b000100, 1'b0);
        xfer1(3, 5, 5, 6'd0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
